// File: rtl/semaforo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | semaforo_pkg - lamp codes, scheduler states, defaults, cfg_sel    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package semaforo_pkg;

  localparam logic [2:0] VERMELHO = 3'b100;
  localparam logic [2:0] AMARELO  = 3'b010;
  localparam logic [2:0] VERDE    = 3'b001;

  typedef enum logic [1:0] {
    ST_OCIOSO  = 2'd0,
    ST_VERDE   = 2'd1,
    ST_AMARELO = 2'd2,
    ST_LIMPEZA = 2'd3
  } estado_t;

  localparam logic [7:0] D_VERDE_PADRAO    = 8'd1;
  localparam logic [7:0] D_AMARELO_PADRAO  = 8'd3;
  localparam logic [7:0] D_VERMELHO_PADRAO = 8'd2;

  localparam logic [1:0] CFG_VERDE   = 2'd0;
  localparam logic [1:0] CFG_AMARELO = 2'd1;
  localparam logic [1:0] CFG_LIMPEZA = 2'd2;

endpackage
`default_nettype wire

// File: rtl/escalonador_cruzamento_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | escalonador_cruzamento_if - buttons, duration config and lamps    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface escalonador_cruzamento_if #(
  parameter int N_VIAS = 4,
  parameter int W_T    = 8
);
  localparam int W_IDX = (N_VIAS > 1) ? $clog2(N_VIAS) : 1;

  logic [N_VIAS-1:0]   bt;
  logic                cfg_we;
  logic [1:0]          cfg_sel;
  logic [W_T-1:0]      cfg_data;
  logic [3*N_VIAS-1:0] luz;
  logic [W_IDX-1:0]    via_ativa;
  logic [N_VIAS-1:0]   pendente;
  logic                ocupado;

  modport master (
    output bt, cfg_we, cfg_sel, cfg_data,
    input  luz, via_ativa, pendente, ocupado
  );

  modport slave (
    input  bt, cfg_we, cfg_sel, cfg_data,
    output luz, via_ativa, pendente, ocupado
  );
endinterface
`default_nettype wire

// File: rtl/arbitro_rr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | arbitro_rr - first set request at or after ptr_i, wrapping around  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module arbitro_rr #(
  parameter int N_VIAS = 4,
  parameter int W_IDX  = (N_VIAS > 1) ? $clog2(N_VIAS) : 1
) (
  input  logic [N_VIAS-1:0] req_i,
  input  logic [W_IDX-1:0]  ptr_i,
  output logic              valido_o,
  output logic [W_IDX-1:0]  idx_o
);

  int j;

  // Scan from the far end back so the candidate closest to ptr_i is written last.
  always_comb begin
    valido_o = 1'b0;
    idx_o    = '0;
    j        = 0;
    for (int k = N_VIAS - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N_VIAS) j = j - N_VIAS;
      if (req_i[j]) begin
        valido_o = 1'b1;
        idx_o    = W_IDX'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/escalonador_cruzamento.sv
`default_nettype none
// +------------------------------------------------------------------+
// | escalonador_cruzamento - round-robin green/yellow/clearance cycle |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module escalonador_cruzamento
  import semaforo_pkg::*;
#(
  parameter int             N_VIAS     = 4,
  parameter int             W_T        = 8,
  parameter logic [W_T-1:0] D_VERDE    = D_VERDE_PADRAO,
  parameter logic [W_T-1:0] D_AMARELO  = D_AMARELO_PADRAO,
  parameter logic [W_T-1:0] D_VERMELHO = D_VERMELHO_PADRAO
) (
  input  logic                      clk,
  input  logic                      rst,
  escalonador_cruzamento_if.slave   bus
);

  localparam int W_IDX = (N_VIAS > 1) ? $clog2(N_VIAS) : 1;

  estado_t             estado_q;
  logic [W_T-1:0]      timer_q;
  logic [W_IDX-1:0]    via_q;
  logic [W_IDX-1:0]    ptr_q;
  logic [N_VIAS-1:0]   pend_q;
  logic [N_VIAS-1:0]   pend_d;
  logic [3*N_VIAS-1:0] luz_q;
  logic                ocupado_q;
  logic [W_T-1:0]      dur_verde_q;
  logic [W_T-1:0]      dur_amarelo_q;
  logic [W_T-1:0]      dur_limpeza_q;

  logic                arb_valido;
  logic [W_IDX-1:0]    arb_idx;
  logic [W_IDX-1:0]    prox_ptr;
  logic                expira;
  logic                inicia;

  arbitro_rr #(
    .N_VIAS (N_VIAS),
    .W_IDX  (W_IDX)
  ) u_arbitro (
    .req_i    (pend_q),
    .ptr_i    (ptr_q),
    .valido_o (arb_valido),
    .idx_o    (arb_idx)
  );

  // A zero duration still yields a one-cycle phase.
  function automatic logic [W_T-1:0] carga(input logic [W_T-1:0] d);
    return (d == '0) ? '0 : d - W_T'(1);
  endfunction

  function automatic logic [3*N_VIAS-1:0] luz_de(input logic [W_IDX-1:0] via,
                                                 input logic [2:0]       cor);
    logic [3*N_VIAS-1:0] r;
    for (int i = 0; i < N_VIAS; i++) begin
      r[3*i +: 3] = (via == W_IDX'(i)) ? cor : VERMELHO;
    end
    return r;
  endfunction

  assign expira   = (timer_q == '0);
  assign inicia   = arb_valido &&
                    ((estado_q == ST_OCIOSO) || ((estado_q == ST_LIMPEZA) && expira));
  assign prox_ptr = (arb_idx == W_IDX'(N_VIAS - 1)) ? '0 : arb_idx + W_IDX'(1);

  // Presses from the approach already in green are dropped; grant clears its bit.
  always_comb begin
    pend_d = pend_q | bus.bt;
    if (estado_q == ST_VERDE) pend_d[via_q] = pend_q[via_q];
    if (inicia) pend_d[arb_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q      <= ST_OCIOSO;
      timer_q       <= '0;
      via_q         <= '0;
      ptr_q         <= '0;
      pend_q        <= '0;
      luz_q         <= {N_VIAS{VERMELHO}};
      ocupado_q     <= 1'b0;
      dur_verde_q   <= D_VERDE;
      dur_amarelo_q <= D_AMARELO;
      dur_limpeza_q <= D_VERMELHO;
    end else begin
      pend_q <= pend_d;

      if (bus.cfg_we) begin
        case (bus.cfg_sel)
          CFG_VERDE:   dur_verde_q   <= bus.cfg_data;
          CFG_AMARELO: dur_amarelo_q <= bus.cfg_data;
          CFG_LIMPEZA: dur_limpeza_q <= bus.cfg_data;
          default:     ;
        endcase
      end

      if (inicia) begin
        estado_q  <= ST_VERDE;
        via_q     <= arb_idx;
        ptr_q     <= prox_ptr;
        timer_q   <= carga(dur_verde_q);
        luz_q     <= luz_de(arb_idx, VERDE);
        ocupado_q <= 1'b1;
      end else begin
        case (estado_q)
          ST_OCIOSO: ;
          ST_VERDE: begin
            if (expira) begin
              estado_q <= ST_AMARELO;
              timer_q  <= carga(dur_amarelo_q);
              luz_q    <= luz_de(via_q, AMARELO);
            end else begin
              timer_q  <= timer_q - W_T'(1);
            end
          end
          ST_AMARELO: begin
            if (expira) begin
              estado_q <= ST_LIMPEZA;
              timer_q  <= carga(dur_limpeza_q);
              luz_q    <= {N_VIAS{VERMELHO}};
            end else begin
              timer_q  <= timer_q - W_T'(1);
            end
          end
          ST_LIMPEZA: begin
            if (expira) begin
              estado_q  <= ST_OCIOSO;
              ocupado_q <= 1'b0;
            end else begin
              timer_q   <= timer_q - W_T'(1);
            end
          end
          default: begin
            estado_q  <= ST_OCIOSO;
            timer_q   <= '0;
            luz_q     <= {N_VIAS{VERMELHO}};
            ocupado_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.luz       = luz_q;
  assign bus.via_ativa = via_q;
  assign bus.pendente  = pend_q;
  assign bus.ocupado   = ocupado_q;

endmodule
`default_nettype wire

// File: tb/tb_escalonador_cruzamento.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_escalonador_cruzamento - scoreboard bench for the scheduler    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_escalonador_cruzamento;
  import semaforo_pkg::*;

  localparam int N  = 4;
  localparam int WT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  escalonador_cruzamento_if #(.N_VIAS(N), .W_T(WT)) bus ();
  escalonador_cruzamento #(.N_VIAS(N), .W_T(WT)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int via; int ini; int nv; int na; int nr; } svc_t;
  typedef struct { int e; logic [N-1:0] p; } pend_t;

  svc_t  fila_svc[$];
  pend_t fila_pend[$];
  int    n_total = 0;
  int    n_pass  = 0;
  int    edge_n;
  bit    mon_en  = 1'b0;

  always @(posedge clk or negedge rst)
    if (!rst) edge_n <= 0;
    else      edge_n <= edge_n + 1;

  task automatic check(input string nome, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: obtido=%0d esperado=%0d (t=%0t)", nome, got, exp, $time);
  endtask

  // Reference model: each service is a set of absolute edge timestamps.
  int          m_dur[3];
  logic [N-1:0] m_pend;
  int          m_prox, m_via, m_ini, m_fimv, m_fima, m_fim;
  bit          m_busy;

  function automatic int ef(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic modelo_reset();
    m_dur[0] = 1; m_dur[1] = 3; m_dur[2] = 2;
    m_pend = '0; m_prox = 0; m_via = 0; m_busy = 1'b0;
    m_ini = 0; m_fimv = -1; m_fima = -1; m_fim = -1;
    fila_svc.delete();
    fila_pend.delete();
  endtask

  task automatic modelo(input int e, input logic [N-1:0] b, input bit we,
                        input int sel, input int d);
    bit em_verde; int esc; int idx; int via_ant; logic [N-1:0] p_ant; svc_t s; pend_t pe;
    em_verde = m_busy && (e > m_ini) && (e <= m_fimv);
    via_ant  = m_via;
    p_ant    = m_pend;
    if (m_busy && e == m_fimv) m_fima = e + ef(m_dur[1]);
    if (m_busy && e == m_fima) begin
      m_fim = e + ef(m_dur[2]);
      s.via = m_via; s.ini = m_ini; s.nv = m_fimv - m_ini;
      s.na = m_fima - m_fimv; s.nr = m_fim - m_fima;
      fila_svc.push_back(s);
    end
    esc = -1;
    if (!m_busy || e == m_fim) begin
      m_busy = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_prox + k) % N;
        if (esc < 0 && p_ant[idx]) esc = idx;
      end
      if (esc >= 0) begin
        m_busy = 1'b1; m_via = esc; m_ini = e; m_fimv = e + ef(m_dur[0]);
        m_fima = -1; m_fim = -1; m_prox = (esc + 1) % N;
      end
    end
    for (int i = 0; i < N; i++)
      if (b[i] && !(em_verde && i == via_ant)) m_pend[i] = 1'b1;
    if (esc >= 0) m_pend[esc] = 1'b0;
    if (we && sel < 3) m_dur[sel] = d;
    pe.e = e; pe.p = m_pend;
    fila_pend.push_back(pe);
  endtask

  // Drive inputs for the next rising edge, then wait for the following falling edge.
  task automatic passo(input logic [N-1:0] b, input bit we = 1'b0,
                       input int sel = 0, input int d = 0);
    bus.bt = b; bus.cfg_we = we; bus.cfg_sel = 2'(sel); bus.cfg_data = 8'(d);
    modelo(edge_n + 1, b, we, sel, d);
    @(negedge clk);
  endtask

  task automatic drenar(input int max);
    int k;
    k = 0;
    while ((m_busy || m_pend != '0) && k < max) begin
      passo('0);
      k++;
    end
    check("dreno_no_limite", (m_busy || m_pend != '0) ? 0 : 1, 1);
    repeat (3) passo('0);
    check("ocupado_apos_dreno", int'(bus.ocupado), 0);
    check("servicos_nao_vistos", fila_svc.size(), 0);
  endtask

  task automatic checar_reset(input string tag);
    logic [3*N-1:0] todas_verm;
    todas_verm = {N{VERMELHO}};
    check({tag, "_luz"}, int'(bus.luz), int'(todas_verm));
    check({tag, "_ocupado"}, int'(bus.ocupado), 0);
    check({tag, "_pendente"}, int'(bus.pendente), 0);
    check({tag, "_via_ativa"}, int'(bus.via_ativa), 0);
  endtask

  // Monitor: measures each observed service and pops the model's expectation.
  int          o_ativo, o_via, o_ini, o_fase;
  int          o_n[3];
  int          nv, g;
  logic [2:0]  cod;
  pend_t       pe_m;

  task automatic fechar();
    svc_t s;
    if (fila_svc.size() == 0) begin
      check("servico_sem_previsao_via", o_via, -1);
      return;
    end
    s = fila_svc.pop_front();
    check("svc_via", o_via, s.via);
    check("svc_inicio", o_ini, s.ini);
    check("svc_verde", o_n[0], s.nv);
    check("svc_amarelo", o_n[1], s.na);
    check("svc_limpeza", o_n[2], s.nr);
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      o_ativo = 0;
    end else begin
      nv = 0; g = 0; cod = VERMELHO;
      for (int i = 0; i < N; i++) begin
        if (bus.luz[3*i +: 3] != VERMELHO) begin
          nv++; g = i; cod = bus.luz[3*i +: 3];
        end
      end
      check("max_uma_via_acesa", (nv <= 1) ? 1 : 0, 1);
      if (nv == 1) check("via_ativa", int'(bus.via_ativa), g);
      while (fila_pend.size() > 0 && fila_pend[0].e < edge_n) void'(fila_pend.pop_front());
      if (fila_pend.size() > 0 && fila_pend[0].e == edge_n) begin
        pe_m = fila_pend.pop_front();
        check("pendente", int'(bus.pendente), int'(pe_m.p));
      end
      if (nv == 1 && cod == VERDE && !(o_ativo != 0 && o_fase == 0 && o_via == g)) begin
        if (o_ativo != 0) fechar();
        o_ativo = 1; o_via = g; o_ini = edge_n; o_fase = 0;
        o_n[0] = 1; o_n[1] = 0; o_n[2] = 0;
      end else if (o_ativo != 0) begin
        if (nv == 1 && cod == VERDE) o_n[0]++;
        else if (nv == 1) begin o_fase = 1; o_n[1]++; end
        else if (bus.ocupado) begin o_fase = 2; o_n[2]++; end
        else begin fechar(); o_ativo = 0; end
      end
    end
  end

  initial begin
    bit achou;
    rst = 1'b0;
    bus.bt = '0; bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_data = '0;
    modelo_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checar_reset("reset_inicial");
    rst = 1'b1;
    mon_en = 1'b1;

    // Single request on approach 2 with default durations
    passo(4'b0100);
    drenar(40);

    // Simultaneous requests served 0, 1, 3 back to back
    passo(4'b1011);
    drenar(60);

    // Green reprogrammed while approach 0 is green; then zero duration
    passo(4'b0011);
    passo('0);
    passo('0, 1'b1, 0, 5);
    drenar(60);
    passo('0, 1'b1, 0, 0);
    passo(4'b0100);
    drenar(40);

    // Asynchronous reset during yellow
    passo(4'b0001);
    achou = 1'b0;
    for (int k = 0; k < 20 && !achou; k++) begin
      passo('0);
      if (bus.luz[2:0] == AMARELO) achou = 1'b1;
    end
    check("espera_amarelo", int'(achou), 1);
    passo(4'b1000);
    passo('0);
    check("amarelo_antes_reset", int'(bus.luz[2:0]), int'(AMARELO));
    check("pendente3_antes_reset", int'(bus.pendente[3]), 1);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1 checar_reset("reset_assincrono");
    @(negedge clk);
    @(negedge clk);
    modelo_reset();
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (3) passo('0);
    check("ocioso_apos_reset", int'(bus.ocupado), 0);

    // Re-request of approach 1: during its green (dropped), during its yellow (kept)
    passo('0, 1'b1, 0, 3);
    passo(4'b0110);
    passo('0);
    passo(4'b0010);
    drenar(80);
    passo(4'b0110);
    repeat (5) passo('0);
    passo(4'b0010);
    drenar(80);

    // Randomized traffic with run-time reconfiguration
    for (int c = 0; c < 300; c++) begin
      logic [N-1:0] b;
      for (int i = 0; i < N; i++) b[i] = ($urandom_range(0, 7) == 0);
      passo(b, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 5)));
    end
    drenar(400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/escalonador_cruzamento.md
# escalonador_cruzamento

- Phase scheduler for an N-approach intersection built from the existing traffic-light encoding.
- Latches vehicle/pedestrian button requests per approach and grants green to one approach at a time, round-robin.
- Each green is sequenced through yellow and an all-red clearance interval, with phase durations programmable at run time.
- Sits between the button inputs and the lamp drivers; replaces fixed-cycle A/B alternation.

## Interface
- `N_VIAS`, default 4: number of approaches (2..8).
- `W_T`, default 8: duration width in cycles.
- `D_VERDE`, default 8'd1: reset value of green duration.
- `D_AMARELO`, default 8'd3: reset value of yellow duration.
- `D_VERMELHO`, default 8'd2: reset value of all-red clearance duration.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `bt` in N_VIAS: request pulse per approach, sampled at `clk` edge, any width.
- `cfg_we` in 1: duration write strobe.
- `cfg_sel` in 2: 0 = green, 1 = yellow, 2 = clearance, 3 = ignored.
- `cfg_data` in W_T: new duration.
- `luz` out 3*N_VIAS: 3-bit lamp code per approach, approach i at bits [3i+2:3i].
- `via_ativa` out clog2(N_VIAS): approach currently in green or yellow.
- `pendente` out N_VIAS: latched, unserved requests.
- `ocupado` out 1: high in every state except OCIOSO.

## Operation
- Lamp codes: 3'b100 red, 3'b010 yellow, 3'b001 green. Only `via_ativa` may be non-red; all others are always 3'b100.
- FSM states:
  - OCIOSO: all red.
  - VERDE: active approach green.
  - AMARELO: active approach yellow.
  - LIMPEZA: all red.
- Transitions:
  - OCIOSO -> VERDE when `pendente` != 0.
  - VERDE -> AMARELO on timer expiry.
  - AMARELO -> LIMPEZA on timer expiry.
  - LIMPEZA -> VERDE on expiry if `pendente` != 0, otherwise -> OCIOSO.
- Request latching:
  - `pendente[i]` is set on any edge with `bt[i]`=1.
  - It is cleared on the edge that enters VERDE for approach i.
  - `bt[i]` for the active approach during VERDE is dropped (already served).
  - `bt[i]` during AMARELO/LIMPEZA is latched (served again later).
- Arbitration:
  - Round-robin search starting at (last served + 1) mod N_VIAS.
  - After reset, search starts at approach 0.
  - Selection is evaluated on the edge leaving OCIOSO/LIMPEZA, using `pendente` as registered before that edge.
- Timer:
  - On each state entry, loads duration-1 and counts down.
  - Each timed state lasts exactly D cycles. A duration of 0 is treated as 1.
- Configuration:
  - A `cfg_we` write updates the duration register on that edge.
  - The running phase is never altered by a write.
  - A write on the same edge as a timer load: the load uses the old value.
- Reset, whenever `rst`=0:
  - State OCIOSO, all `luz` = 3'b100, `pendente`=0, `via_ativa`=0, `ocupado`=0, timer 0.
  - Durations return to D_* defaults, round-robin pointer set so approach 0 is first.
  - Mid-phase reset forces red immediately (asynchronous), with no yellow.

## Timing
- Request latency:
  - `bt[i]` sampled at edge k -> `pendente[i]`=1 after edge k.
  - OCIOSO -> VERDE at edge k+1, `luz` green visible after edge k+1.
- Full service of one approach: D_VERDE + D_AMARELO + D_VERMELHO cycles from VERDE entry to leaving LIMPEZA.
- Back-to-back service: LIMPEZA expiry goes directly to the next VERDE with no OCIOSO cycle.
- All outputs are registered; no combinational path from `bt`/`cfg_*` to outputs.

## Structure
- Package `semaforo_pkg` holds:
  - Lamp code constants VERMELHO/AMARELO/VERDE (3'b100/3'b010/3'b001).
  - FSM state enum.
  - Default durations 8'd1 / 8'd3 / 8'd2.
  - `cfg_sel` encodings.
- Sub-module `arbitro_rr`: parameterized round-robin picker (inputs: request vector, pointer; outputs: valid, index).
- Timer and FSM stay in the top module.

## Test plan
1. Reset: hold `rst`=0 for 2 cycles -> all `luz`=3'b100, `ocupado`=0, `pendente`=0.
2. Single request: `bt`=4'b0100 for 1 cycle at edge 1, defaults.
   - Approach 2 green for edges 2..3 (1 cycle), yellow for 3 cycles, all-red for 2 cycles.
   - Then OCIOSO, `ocupado`=0.
3. Simultaneous requests: `bt`=4'b1011 for 1 cycle -> greens in order 0, 1, 3, each separated by yellow+clearance, with no OCIOSO between them.
4. Reconfiguration: write `cfg_sel`=0, `cfg_data`=5 during approach 0 green.
   - Current green stays 1 cycle.
   - Next approach's green lasts 5 cycles.
   - `cfg_data`=0 yields a 1-cycle phase.
5. Re-request: `bt[1]` during approach 1 VERDE -> dropped. `bt[1]` during its AMARELO -> latched, approach 1 served again after the other pending approaches.
6. Reset mid-operation: `rst`=0 during AMARELO -> `luz` all red immediately (before the next edge), `pendente` cleared, OCIOSO after release.
